// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//
// Turns the byte stream from a PS/2 receiver (scan-code set 2) into key events.
// The decoder handles the E0 extended prefix and the F0 break prefix. It emits one
// key_valid pulse for each complete make or break sequence. It also keeps a
// 7-segment glyph of the last released letter key for a display.
//
// Parameters
//   IDLE_TIMEOUT    clk cycles allowed between bytes of one sequence before it is dropped
//   CNT_W           width of the inter-byte timeout counter (must hold IDLE_TIMEOUT-1)
//   SEG_ACTIVE_LOW  1: seg_out inverted for a common-anode display; 0: active-high
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   byte_in       received scan-code byte, sampled only while byte_valid is high
//   byte_valid    1-cycle strobe from the PS/2 receiver
//   key_code      final (non-prefix) byte of the last event
//   key_release   last event was a break (F0 seen)
//   key_extended  last event carried the E0 prefix
//   key_valid     1-cycle pulse; key_* are valid on this cycle
//   seg_out       glyph, bit order {g,f,e,d,c,b,a}
//   unknown_key   displayed glyph is the dash (letter without a 7-segment font)

module ps2_key_decoder #(
  parameter int unsigned IDLE_TIMEOUT   = 1000000,
  parameter int unsigned CNT_W          = 20,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       key_valid,
  output logic [6:0] seg_out,
  output logic       unknown_key
);

  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBreak = 8'hF0;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGotE0,
    StGotF0,
    StGotE0F0
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  // Glyph is held active-high internally and inverted at the port if required.
  logic [6:0]       seg_q;

  // Byte decode for the current state.
  logic emit;
  logic emit_rel;
  logic emit_ext;

  // Letter lookup: {hit, unknown, glyph}.
  logic       glyph_hit;
  logic       glyph_unknown;
  logic [6:0] glyph;

  // Power-on/self-test and host-protocol responses carry no key information.
  function automatic logic is_ignored(input logic [7:0] code);
    return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) || (code == 8'hEE);
  endfunction

  function automatic logic [8:0] letter_glyph(input logic [7:0] code);
    logic [8:0] r;
    r = 9'b0;
    unique case (code)
      8'h1C: r = {2'b10, 7'h77}; // A
      8'h32: r = {2'b10, 7'h7C}; // B
      8'h21: r = {2'b10, 7'h39}; // C
      8'h23: r = {2'b10, 7'h5E}; // D
      8'h24: r = {2'b10, 7'h79}; // E
      8'h2B: r = {2'b10, 7'h71}; // F
      8'h34: r = {2'b10, 7'h3D}; // G
      8'h33: r = {2'b10, 7'h76}; // H
      8'h43: r = {2'b10, 7'h30}; // I
      8'h3B: r = {2'b10, 7'h1E}; // J
      8'h4B: r = {2'b10, 7'h38}; // L
      8'h31: r = {2'b10, 7'h54}; // N
      8'h44: r = {2'b10, 7'h5C}; // O
      8'h4D: r = {2'b10, 7'h73}; // P
      8'h15: r = {2'b10, 7'h67}; // Q
      8'h2D: r = {2'b10, 7'h50}; // R
      8'h1B: r = {2'b10, 7'h6D}; // S
      8'h2C: r = {2'b10, 7'h78}; // T
      8'h3C: r = {2'b10, 7'h3E}; // U
      8'h35: r = {2'b10, 7'h6E}; // Y
      // Letters that cannot be drawn legibly on 7 segments show a dash.
      8'h42, 8'h3A, 8'h2A, 8'h1D, 8'h22, 8'h1A: r = {2'b11, 7'h40};
      default: r = 9'b0;
    endcase
    return r;
  endfunction

  assign {glyph_hit, glyph_unknown, glyph} = letter_glyph(byte_in);

  // Next state and event decode for an accepted byte.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_rel = 1'b0;
    emit_ext = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (byte_in == CodeExt) begin
          state_d = StGotE0;
        end else if (byte_in == CodeBreak) begin
          state_d = StGotF0;
        end else if (!is_ignored(byte_in)) begin
          emit = 1'b1;
        end
      end
      StGotE0: begin
        if (byte_in == CodeBreak) begin
          state_d = StGotE0F0;
        end else if (byte_in != CodeExt) begin
          // A repeated E0 keeps waiting; anything else completes the make.
          state_d  = StIdle;
          emit     = 1'b1;
          emit_ext = 1'b1;
        end
      end
      StGotF0: begin
        state_d = StIdle;
        // A prefix directly after F0 is malformed and dropped silently.
        if (byte_in != CodeBreak && byte_in != CodeExt) begin
          emit     = 1'b1;
          emit_rel = 1'b1;
        end
      end
      StGotE0F0: begin
        state_d = StIdle;
        if (byte_in != CodeBreak && byte_in != CodeExt) begin
          emit     = 1'b1;
          emit_rel = 1'b1;
          emit_ext = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      key_code     <= 8'h00;
      key_release  <= 1'b0;
      key_extended <= 1'b0;
      key_valid    <= 1'b0;
      unknown_key  <= 1'b0;
      seg_q        <= 7'h00;
    end else begin
      key_valid <= 1'b0;
      if (byte_valid) begin
        // An arriving byte takes priority over a timeout expiring in the same cycle.
        cnt_q   <= '0;
        state_q <= state_d;
        if (emit) begin
          key_valid    <= 1'b1;
          key_code     <= byte_in;
          key_release  <= emit_rel;
          key_extended <= emit_ext;
          if (emit_rel && !emit_ext && glyph_hit) begin
            seg_q       <= glyph;
            unknown_key <= glyph_unknown;
          end
        end
      end else if (state_q == StIdle) begin
        cnt_q <= '0;
      end else if (cnt_q == TimeoutLast) begin
        // Stale partial sequence: abandon it without an event.
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign seg_out = SEG_ACTIVE_LOW ? ~seg_q : seg_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

  localparam int unsigned Timeout = 16;

  // Active-low glyphs as they appear on seg_out.
  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegA     = ~7'h77;
  localparam logic [6:0] SegDash  = ~7'h40;
  localparam logic [6:0] SegE     = ~7'h79;
  localparam logic [6:0] SegF     = ~7'h71;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic [7:0] key_code;
  logic       key_release;
  logic       key_extended;
  logic       key_valid;
  logic [6:0] seg_out;
  logic       unknown_key;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int base;

  ps2_key_decoder #(
    .IDLE_TIMEOUT  (Timeout),
    .CNT_W         (5),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .key_code    (key_code),
    .key_release (key_release),
    .key_extended(key_extended),
    .key_valid   (key_valid),
    .seg_out     (seg_out),
    .unknown_key (unknown_key)
  );

  always #5 clk = ~clk;

  // Each pulse is high across exactly one falling edge.
  always @(negedge clk) if (key_valid === 1'b1) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; the byte is sampled at the next rising edge.
  // Returns 1ns after the following falling edge, while any resulting pulse is visible.
  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_event(input string tag, input logic [7:0] code, input logic rel,
                           input logic ext);
    chk({tag, "_valid"}, key_valid, 1'b1);
    chk({tag, "_code"}, key_code, code);
    chk({tag, "_rel"}, key_release, rel);
    chk({tag, "_ext"}, key_extended, ext);
  endtask

  initial begin
    // Reset
    idle(3);
    rst = 1'b0;
    chk("rst_code", key_code, 8'h00);
    chk("rst_rel", key_release, 1'b0);
    chk("rst_ext", key_extended, 1'b0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_unk", unknown_key, 1'b0);
    chk("rst_seg", seg_out, SegBlank);
    idle(1);

    // Make then break of A
    send_byte(8'h1C);
    chk_event("make_a", 8'h1C, 1'b0, 1'b0);
    chk("make_a_seg", seg_out, SegBlank);
    idle(1);
    chk("pulse_one_cycle", key_valid, 1'b0);
    send_byte(8'hF0);
    chk("f0_no_pulse", key_valid, 1'b0);
    idle(1);
    send_byte(8'h1C);
    chk_event("brk_a", 8'h1C, 1'b1, 1'b0);
    chk("brk_a_seg", seg_out, SegA);
    chk("brk_a_unk", unknown_key, 1'b0);
    idle(2);

    // Ignored host-response byte in IDLE
    base = pulses;
    send_byte(8'hFA);
    idle(1);
    chk("ignore_fa", pulses - base, 0);

    // Extended make and break: display untouched
    send_byte(8'hE0);
    send_byte(8'h74);
    chk_event("ext_make", 8'h74, 1'b0, 1'b1);
    idle(1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    chk_event("ext_brk", 8'h74, 1'b1, 1'b1);
    chk("ext_brk_seg", seg_out, SegA);
    idle(1);

    // Dash letter, then a real glyph clears unknown_key
    send_byte(8'hF0);
    send_byte(8'h42);
    chk_event("brk_k", 8'h42, 1'b1, 1'b0);
    chk("brk_k_seg", seg_out, SegDash);
    chk("brk_k_unk", unknown_key, 1'b1);
    idle(1);
    send_byte(8'hF0);
    send_byte(8'h24);
    chk("brk_e_seg", seg_out, SegE);
    chk("brk_e_unk", unknown_key, 1'b0);
    idle(1);

    // Timeout: F0 then Timeout idle cycles, so 1C is a fresh make
    base = pulses;
    send_byte(8'hF0);
    idle(Timeout);
    chk("tmo_no_pulse", pulses - base, 0);
    send_byte(8'h1C);
    chk_event("tmo_make", 8'h1C, 1'b0, 1'b0);
    chk("tmo_seg", seg_out, SegE);
    idle(1);

    // Byte arriving on the expiry cycle wins: still a break
    send_byte(8'hF0);
    idle(Timeout - 1);
    send_byte(8'h1C);
    chk_event("edge_brk", 8'h1C, 1'b1, 1'b0);
    chk("edge_seg", seg_out, SegA);
    idle(1);

    // Reset between F0 and 1C
    base = pulses;
    send_byte(8'hF0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_valid", key_valid, 1'b0);
    chk("midrst_seg", seg_out, SegBlank);
    chk("midrst_code", key_code, 8'h00);
    chk("midrst_no_pulse", pulses - base, 0);
    send_byte(8'h1C);
    chk_event("midrst_make", 8'h1C, 1'b0, 1'b0);
    chk("midrst_seg2", seg_out, SegBlank);
    idle(2);

    // Back-to-back strobes
    base = pulses;
    send_byte(8'hF0);
    send_byte(8'h2B);
    chk_event("b2b_brk", 8'h2B, 1'b1, 1'b0);
    chk("b2b_seg", seg_out, SegF);
    idle(2);
    chk("b2b_one_pulse", pulses - base, 1);
    chk("b2b_hold_code", key_code, 8'h2B);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
